// File: rtl/seg7_pkg.sv
// Shared constants, scan FSM state encoding and width helper for the seg7 scan controller.
package seg7_pkg;

  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  typedef logic [0:0] scan_state_t;
  localparam scan_state_t ST_BLANK = 1'b0;
  localparam scan_state_t ST_DRIVE = 1'b1;

  // Minimum width of 1 so a single-value counter still gets a real bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_dec.sv
// BCD to seven-segment decoder, segments {g,f,e,d,c,b,a} active-high; codes above 9 give SEG_OFF.
module seg7_scan_ctrl_dec (
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);
  import seg7_pkg::*;

  always_comb begin
    o_seg = SEG_OFF;
    case (i_code)
      4'd0: o_seg = 7'b0111111;
      4'd1: o_seg = 7'b0000110;
      4'd2: o_seg = 7'b1011011;
      4'd3: o_seg = 7'b1001111;
      4'd4: o_seg = 7'b1100110;
      4'd5: o_seg = 7'b1101101;
      4'd6: o_seg = 7'b1111101;
      4'd7: o_seg = 7'b0000111;
      4'd8: o_seg = 7'b1111111;
      4'd9: o_seg = 7'b1101111;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller: snapshot register, slot timer, BLANK/DRIVE FSM.
// Optional leading-zero blanking is compiled in with SEG7_SCAN_LZB_EN.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit DIG_ACT_LOW  = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [4*NUM_DIGITS-1:0] i_bcd_in,
  input  logic                    i_load,
  input  logic                    i_blank_all,
  output logic [6:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_dig_en,
  output logic                    o_slot_tick,
  output logic [0:0]              o_dbg_state
);
  import seg7_pkg::*;

  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam int CNT_W = clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SLOT_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_BLK  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACT_LOW}};

  logic [4*NUM_DIGITS-1:0] r_snap;
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_cnt;
  scan_state_t             r_state;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_dig;
  logic                    r_tick;
  logic                    r_hide;

  logic [3:0]            w_code;
  logic [6:0]            w_dec;
  logic [6:0]            w_seg_nxt;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic                  w_hide;
  logic                  w_zero_run;

  always_comb begin
    w_code   = 4'd0;
    w_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_code      = r_snap[4*i +: 4];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // A digit is hidden when it and every digit above it are zero; digit 0 is never hidden.
  always_comb begin
    w_hide     = 1'b0;
    w_zero_run = 1'b1;
`ifdef SEG7_SCAN_LZB_EN
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run & (r_snap[4*i +: 4] == 4'd0);
      if (r_idx == IDX_W'(i)) w_hide = w_zero_run;
    end
`else
    w_hide     = 1'b0;
    w_zero_run = 1'b0;
`endif
  end

  seg7_scan_ctrl_dec u_dec (
    .i_code (w_code),
    .o_seg  (w_dec)
  );

  always_comb begin
    w_seg_nxt = w_dec;
    if (w_hide)            w_seg_nxt = SEG_OFF;
    else if (w_code > 4'd9) w_seg_nxt = SEG_DASH;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_snap  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_state <= ST_BLANK;
      r_seg   <= SEG_OFF;
      r_dig   <= DIG_OFF;
      r_tick  <= 1'b0;
      r_hide  <= 1'b0;
    end else begin
      if (i_load) r_snap <= i_bcd_in;
      r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      r_tick <= (r_cnt == CNT_PRE);
      r_dig  <= DIG_OFF;
      // seg and the hide decision are latched once per slot, at BLANK->DRIVE only.
      case (r_state)
        ST_BLANK: begin
          if (r_cnt == CNT_BLK) begin
            r_state <= ST_DRIVE;
            r_seg   <= w_seg_nxt;
            r_hide  <= w_hide;
            if (!i_blank_all && !w_hide) r_dig <= w_onehot ^ DIG_OFF;
          end
        end
        ST_DRIVE: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_BLANK;
            r_seg   <= SEG_OFF;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
          end else if (!i_blank_all && !r_hide) begin
            r_dig <= w_onehot ^ DIG_OFF;
          end
        end
        default: r_state <= ST_BLANK;
      endcase
    end
  end

  assign o_seg       = r_seg;
  assign o_dig_en    = r_dig;
  assign o_slot_tick = r_tick;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a short slot (20 cycles, 4 dead-time cycles, 4 digits).
module tb_seg7_scan_ctrl;

`ifdef SEG7_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [15:0] i_bcd_in = 16'h0000;
  logic        i_load = 1'b0;
  logic        i_blank_all = 1'b0;
  logic [6:0]  o_seg;
  logic [3:0]  o_dig_en;
  logic        o_slot_tick;
  logic [0:0]  o_dbg_state;

  int total = 0;
  int bad = 0;
  logic [6:0] exp_q[$];
  logic [3:0] dig_q[$];

  // clock / reset
  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS(4), .SLOT_CYCLES(20), .BLANK_CYCLES(4), .DIG_ACT_LOW(1'b1)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_bcd_in    (i_bcd_in),
    .i_load      (i_load),
    .i_blank_all (i_blank_all),
    .o_seg       (o_seg),
    .o_dig_en    (o_dig_en),
    .o_slot_tick (o_slot_tick),
    .o_dbg_state (o_dbg_state)
  );

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (o_slot_tick !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    chk({tag, "_tick_seen"}, 32'(n < 40), 32'd1);
  endtask

  // Starts on the last cycle of a slot; walks through the next slot and ends on its last cycle.
  task automatic slot_body(input string tag, input logic [3:0] edig, input logic [6:0] eseg);
    tick(1);
    i_load = 1'b0;
    chk({tag, "_dark_dig"}, 32'(o_dig_en), 32'h0f);
    chk({tag, "_dark_seg"}, 32'(o_seg), 32'h00);
    tick(3);
    chk({tag, "_dead_end_dig"}, 32'(o_dig_en), 32'h0f);
    tick(1);
    chk({tag, "_dig"}, 32'(o_dig_en), 32'(edig));
    chk({tag, "_seg"}, 32'(o_seg), 32'(eseg));
    tick(15);
    chk({tag, "_last_tick"}, 32'(o_slot_tick), 32'd1);
    chk({tag, "_last_dig"}, 32'(o_dig_en), 32'(edig));
  endtask

  task automatic check_slot(input string tag, input logic [3:0] edig, input logic [6:0] eseg);
    wait_tick(tag);
    slot_body(tag, edig, eseg);
  endtask

  initial begin : main
    int ticks;
    logic dark_ok;

    // reset state and first enable after release
    tick(3);
    chk("rst_dig", 32'(o_dig_en), 32'h0f);
    chk("rst_seg", 32'(o_seg), 32'h00);
    chk("rst_tick", 32'(o_slot_tick), 32'd0);
    chk("rst_state", 32'(o_dbg_state), 32'd0);
    i_reset = 1'b0;
    tick(3);
    chk("post_rst_dark", 32'(o_dig_en), 32'h0f);
    tick(1);
    chk("first_dig", 32'(o_dig_en), 32'h0e);
    chk("first_seg", 32'(o_seg), 32'h3f);
    chk("first_state", 32'(o_dbg_state), 32'd1);

    // load 1234 mid-DRIVE of digit 0: seg holds, then full scan with wrap
    i_bcd_in = 16'h1234; i_load = 1'b1;
    tick(1);
    i_load = 1'b0;
    chk("load_no_glitch", 32'(o_seg), 32'h3f);
    exp_q.push_back(7'h4f); dig_q.push_back(4'b1101);
    exp_q.push_back(7'h5b); dig_q.push_back(4'b1011);
    exp_q.push_back(7'h06); dig_q.push_back(4'b0111);
    exp_q.push_back(7'h66); dig_q.push_back(4'b1110);
    while (exp_q.size() > 0) begin
      logic [6:0] es;
      logic [3:0] ed;
      es = exp_q.pop_front();
      ed = dig_q.pop_front();
      check_slot("scan1234", ed, es);
    end

    // load 00A7 on the slot_tick cycle: next slot already uses the new snapshot
    i_bcd_in = 16'h00a7; i_load = 1'b1;
    slot_body("a7_d1", 4'b1101, 7'b1000000);
    check_slot("a7_d2", LZB ? 4'b1111 : 4'b1011, LZB ? 7'h00 : 7'h3f);
    check_slot("a7_d3", LZB ? 4'b1111 : 4'b0111, LZB ? 7'h00 : 7'h3f);
    check_slot("a7_d0", 4'b1110, 7'b0000111);
    check_slot("a7_d1b", 4'b1101, 7'b1000000);

    // load 9999 mid-DRIVE of digit 2: seg unchanged until its next slot
    wait_tick("d2_mid");
    tick(5);
    chk("d2_pre_seg", 32'(o_seg), LZB ? 32'h00 : 32'h3f);
    tick(5);
    i_bcd_in = 16'h9999; i_load = 1'b1;
    tick(1);
    i_load = 1'b0;
    chk("d2_hold_seg", 32'(o_seg), LZB ? 32'h00 : 32'h3f);
    chk("d2_hold_dig", 32'(o_dig_en), LZB ? 32'h0f : 32'h0b);
    tick(9);
    chk("d2_end_seg", 32'(o_seg), LZB ? 32'h00 : 32'h3f);
    check_slot("n9_d3", 4'b0111, 7'h6f);
    check_slot("n9_d0", 4'b1110, 7'h6f);
    check_slot("n9_d1", 4'b1101, 7'h6f);
    check_slot("n9_d2", 4'b1011, 7'h6f);

    // blank_all for 30 cycles: dark, timer keeps ticking, enable returns next cycle
    i_blank_all = 1'b1;
    ticks = 0;
    dark_ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (o_slot_tick === 1'b1) ticks++;
      if (o_dig_en !== 4'b1111) dark_ok = 1'b0;
    end
    chk("blank_dark", 32'(dark_ok), 32'd1);
    chk("blank_ticks", 32'(ticks), 32'd1);
    chk("blank_seg_kept", 32'(o_seg), 32'h6f);
    i_blank_all = 1'b0;
    tick(1);
    chk("unblank_dig", 32'(o_dig_en), 32'h0e);
    check_slot("unblank_d1", 4'b1101, 7'h6f);

    // all-zero word: only digit 0 lit with leading-zero blanking
    i_bcd_in = 16'h0000; i_load = 1'b1;
    slot_body("z_d2", LZB ? 4'b1111 : 4'b1011, LZB ? 7'h00 : 7'h3f);
    check_slot("z_d3", LZB ? 4'b1111 : 4'b0111, LZB ? 7'h00 : 7'h3f);
    check_slot("z_d0", 4'b1110, 7'h3f);
    check_slot("z_d1", LZB ? 4'b1111 : 4'b1101, LZB ? 7'h00 : 7'h3f);

    // reset mid-DRIVE of digit 2 aborts the slot and restarts at digit 0
    i_bcd_in = 16'h5678; i_load = 1'b1;
    tick(1);
    i_load = 1'b0;
    tick(5);
    i_reset = 1'b1;
    tick(1);
    chk("mid_rst_dig", 32'(o_dig_en), 32'h0f);
    chk("mid_rst_seg", 32'(o_seg), 32'h00);
    chk("mid_rst_state", 32'(o_dbg_state), 32'd0);
    i_reset = 1'b0;
    tick(3);
    chk("mid_rst_dark", 32'(o_dig_en), 32'h0f);
    tick(1);
    chk("mid_rst_dig0", 32'(o_dig_en), 32'h0e);
    chk("mid_rst_seg0", 32'(o_seg), 32'h3f);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
